// File: rtl/vp_pkg.sv
// Shared definitions for the vector processor issue path: opcodes, instruction width, issue FSM states.
package vp_pkg;

    localparam int unsigned INSTR_W = 13;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_MUL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } issue_state_e;

endpackage

// File: rtl/vp_sync_fifo.sv
// Synchronous FIFO with occupancy count; full/empty derive from the count, pointers wrap modulo DEPTH.
module vp_sync_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vp_instr_issue.sv
// Instruction issue stage: buffers host instructions and issues one per cycle, stalling ADD/MUL after a LOAD.
// Optional statistics counters (issued_cnt, stall_cnt) are enabled by defining VP_ISSUE_STATS_EN.
module vp_instr_issue
    import vp_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned INSTR_W  = vp_pkg::INSTR_W,
    parameter int unsigned LOAD_GAP = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [INSTR_W-1:0]     in_instr,
    output logic                   in_ready,
    input  logic                   run,
    input  logic                   flush,
    output logic [INSTR_W-1:0]     instr,
    output logic                   instr_valid,
    output logic [$clog2(DEPTH):0] level
`ifdef VP_ISSUE_STATS_EN
    ,
    output logic [31:0]            issued_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = 3;

    logic [INSTR_W-1:0] head;
    logic [LW-1:0]      count;
    logic               full;
    logic               empty;
    logic [1:0]         head_op_c;
    logic               push_c;
    logic               hazard_c;
    logic               issue_c;
    logic [GW-1:0]      gap_cnt;
    logic [GW-1:0]      gap_nxt;
    issue_state_e       state;
    issue_state_e       state_nxt;

    vp_sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .push    (push_c),
        .pop     (issue_c),
        .data_in (in_instr),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign in_ready  = !full;
    assign level     = count;
    assign head_op_c = head[INSTR_W-1 -: 2];
    assign push_c    = in_valid && !full && !flush;
    assign hazard_c  = ((head_op_c == OP_ADD) || (head_op_c == OP_MUL)) && (gap_cnt != '0);
    assign issue_c   = run && !empty && !hazard_c && !flush;

    // Next state reflects what happens on the coming edge; gap counter reloads on every issued LOAD.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        if (flush || !run || empty) begin
            state_nxt = IDLE;
        end else if (hazard_c) begin
            state_nxt = STALL;
        end else begin
            state_nxt = ISSUE;
        end
        if (flush) begin
            gap_nxt = '0;
        end else if (issue_c && (head_op_c == OP_LOAD)) begin
            gap_nxt = GW'(LOAD_GAP);
        end else if (gap_cnt != '0) begin
            gap_nxt = gap_cnt - GW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            gap_cnt     <= gap_nxt;
            instr_valid <= issue_c;
            if (issue_c) begin
                instr <= head;
            end
        end
    end

`ifdef VP_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else if (flush) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (issue_c) begin
                issued_cnt <= issued_cnt + 32'd1;
            end
            if (state == STALL) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
